// File: rtl/spike_rr_scheduler.sv
// Round-robin spike scheduler: arbitrates N_IN requesters onto one weight ROM and one
// integrate-and-fire accumulator with threshold, saturation and refractory handling.
module spike_rr_scheduler #(
  parameter int unsigned         N_IN       = 8,
  parameter int unsigned         W_BITS     = 8,
  parameter int unsigned         ACC_BITS   = 11,
  parameter logic [ACC_BITS-1:0] THETA      = 11'h1FF,
  parameter int unsigned         REFRACTORY = 50000
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [N_IN-1:0]                   spikes_in,
  output logic [N_IN-1:0]                   acks_out,
  output logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] rom_addr,
  output logic                              rom_rd_en,
  input  logic [W_BITS-1:0]                 rom_data,
  output logic                              spike_out,
  output logic [ACC_BITS-1:0]               potential_out,
  output logic                              busy
);

  localparam int unsigned AW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned RW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  typedef enum logic [1:0] {StIdle, StRead, StAccum, StAck} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       rr_q, rr_d;
  logic [AW-1:0]       grant_q, grant_d;
  logic [N_IN-1:0]     acks_q, acks_d;
  logic [AW-1:0]       rom_addr_q, rom_addr_d;
  logic                rom_rd_en_q, rom_rd_en_d;
  logic                spike_q, spike_d;
  logic [ACC_BITS-1:0] pot_q, pot_d;
  logic [RW-1:0]       refr_q, refr_d;

  logic [AW-1:0]       pick;
  logic [AW-1:0]       idx_w;
  int unsigned         idx;
  logic                found;
  logic [ACC_BITS:0]   sum;
  logic [ACC_BITS-1:0] sat;
  logic                refractory;

  assign refractory = (refr_q != '0);

  // First requester at or above the rr pointer, wrapping to 0.
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      idx   = (32'(rr_q) + i) % N_IN;
      idx_w = AW'(idx);
      if (!found && spikes_in[idx_w]) begin
        found = 1'b1;
        pick  = idx_w;
      end
    end
  end

  always_comb begin
    sum = {1'b0, pot_q} + (ACC_BITS + 1)'(rom_data);
    sat = sum[ACC_BITS] ? {ACC_BITS{1'b1}} : sum[ACC_BITS-1:0];
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    acks_d      = acks_q;
    rom_addr_d  = rom_addr_q;
    rom_rd_en_d = 1'b0;
    spike_d     = 1'b0;
    pot_d       = pot_q;
    refr_d      = refractory ? refr_q - RW'(1) : refr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          if (refractory) begin
            // Weight is discarded: acknowledge straight away without touching the ROM.
            acks_d  = N_IN'(1) << pick;
            state_d = StAck;
          end else begin
            rom_rd_en_d = 1'b1;
            rom_addr_d  = pick;
            state_d     = StRead;
          end
        end
      end
      StRead: state_d = StAccum;
      StAccum: begin
        if (sat > THETA) begin
          pot_d   = '0;
          spike_d = 1'b1;
          refr_d  = RW'(REFRACTORY);
        end else begin
          pot_d = sat;
        end
        acks_d  = N_IN'(1) << grant_q;
        state_d = StAck;
      end
      StAck: begin
        if (!spikes_in[grant_q]) begin
          acks_d  = '0;
          rr_d    = (32'(grant_q) == N_IN - 1) ? '0 : grant_q + AW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      grant_q     <= '0;
      acks_q      <= '0;
      rom_addr_q  <= '0;
      rom_rd_en_q <= 1'b0;
      spike_q     <= 1'b0;
      pot_q       <= '0;
      refr_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      acks_q      <= acks_d;
      rom_addr_q  <= rom_addr_d;
      rom_rd_en_q <= rom_rd_en_d;
      spike_q     <= spike_d;
      pot_q       <= pot_d;
      refr_q      <= refr_d;
    end
  end

  assign acks_out      = acks_q;
  assign rom_addr      = rom_addr_q;
  assign rom_rd_en     = rom_rd_en_q;
  assign spike_out     = spike_q;
  assign potential_out = pot_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_spike_rr_scheduler.sv
// Bench for spike_rr_scheduler: randomized requesters against a transaction-level neuron model,
// plus directed threshold, refractory, saturation and reset scenarios.
module tb_spike_rr_scheduler;

  localparam int THETA_A = 511;
  localparam int REFR_A  = 20;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  spikes_in, acks_out;
  logic [2:0]  rom_addr;
  logic        rom_rd_en, spike_out, busy;
  logic [7:0]  rom_data;
  logic [10:0] potential_out;

  logic [7:0]  spikes2, acks2;
  logic [2:0]  rom_addr2;
  logic        rom_rd_en2, spike2, busy2;
  logic [7:0]  rom_data2;
  logic [10:0] pot2;
  logic        seen2 = 1'b0;

  logic [7:0]  weights [8];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  spike_rr_scheduler #(.N_IN(8), .W_BITS(8), .ACC_BITS(11), .THETA(11'h1FF),
                       .REFRACTORY(REFR_A)) u_dut (
    .clk(clk), .resetn(resetn), .spikes_in(spikes_in), .acks_out(acks_out),
    .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_data(rom_data),
    .spike_out(spike_out), .potential_out(potential_out), .busy(busy)
  );

  spike_rr_scheduler #(.N_IN(8), .W_BITS(8), .ACC_BITS(11), .THETA(11'h7FF),
                       .REFRACTORY(0)) u_dut_sat (
    .clk(clk), .resetn(resetn), .spikes_in(spikes2), .acks_out(acks2),
    .rom_addr(rom_addr2), .rom_rd_en(rom_rd_en2), .rom_data(rom_data2),
    .spike_out(spike2), .potential_out(pot2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM returns data the cycle after the read strobe.
  always @(posedge clk) begin
    if (rom_rd_en)  rom_data  <= weights[rom_addr];
    if (rom_rd_en2) rom_data2 <= weights[rom_addr2];
    if (spike2)     seen2     <= 1'b1;
  end

  // Transaction-level neuron model.
  bit         m_busy, m_drop;
  int         m_k, m_g, m_ack_edge, m_ptr, m_pot, m_refr_end;
  logic [7:0] e_ack, used, first_ack;
  logic [2:0] e_addr;
  bit         e_rd, e_spike;
  int         fires;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] req, input int ptr);
    for (int i = 0; i < 8; i++) if (req[(ptr + i) % 8]) return (ptr + i) % 8;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_pot = 0; m_refr_end = -1;
    e_ack = '0; e_rd = 0; e_spike = 0; e_addr = '0;
  endtask

  // Advance the model across the coming edge n with the request vector it will sample.
  task automatic model_edge(input logic [7:0] req, input int n);
    int s;
    e_rd = 0; e_spike = 0;
    if (!m_busy) begin
      if (req != 0) begin
        m_busy = 1; m_k = n; m_g = pick(req, m_ptr);
        m_drop = (n <= m_refr_end);
        m_ack_edge = m_drop ? n : n + 2;
        e_rd = !m_drop; e_addr = 3'(m_g);
      end
    end else if (n > m_ack_edge) begin
      if (!req[m_g]) begin m_busy = 0; m_ptr = (m_g + 1) % 8; end
    end else if (n == m_ack_edge) begin
      s = m_pot + int'(weights[m_g]);
      if (s > 2047) s = 2047;
      if (s > THETA_A) begin m_pot = 0; e_spike = 1; m_refr_end = n + REFR_A; end
      else m_pot = s;
    end
    e_ack = (m_busy && n >= m_ack_edge) ? (8'(1) << m_g) : 8'h00;
  endtask

  task automatic run(input logic [7:0] mask, input int raise_pct, input int hold_pct,
                     input int glitch_pct, input int max_cyc, input bit oneshot);
    for (int c = 0; c < max_cyc; c++) begin
      check_eq("ack", acks_out, e_ack);
      check_eq("busy", busy, m_busy);
      check_eq("rd_en", rom_rd_en, e_rd);
      if (e_rd) check_eq("addr", rom_addr, e_addr);
      check_eq("spike", spike_out, e_spike);
      check_eq("pot", potential_out, m_pot);
      if (spike_out) fires++;
      if (acks_out != 0 && first_ack == 0) first_ack = acks_out;
      if (oneshot && ((used & mask) == mask) && spikes_in == 0 && !m_busy) break;
      for (int i = 0; i < 8; i++) begin
        if (spikes_in[i]) begin
          if (acks_out[i] && $urandom_range(99) < hold_pct) spikes_in[i] = 1'b0;
          else if (!acks_out[i] && $urandom_range(99) < glitch_pct) spikes_in[i] = 1'b0;
        end else if (mask[i] && !(oneshot && used[i]) && !acks_out[i] &&
                     $urandom_range(99) < raise_pct) begin
          spikes_in[i] = 1'b1;
          used[i] = 1'b1;
        end
      end
      model_edge(spikes_in, cyc);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    spikes_in = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    bit got;
    resetn = 1'b0; spikes_in = '0; spikes2 = '0; used = '0; fires = 0; first_ack = '0;
    for (int i = 0; i < 8; i++) weights[i] = 8'h00;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_eq("rst_ack", acks_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pot", potential_out, 0);
    check_eq("rst_rd", rom_rd_en, 0);
    check_eq("rst_addr", rom_addr, 0);
    check_eq("rst_spike", spike_out, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Single request on line 3.
    weights[3] = 8'h40;
    used = '0;
    run(8'h08, 100, 100, 0, 30, 1);
    check_eq("single_pot", potential_out, 64);

    // All lines held, then lines 0 and 5 again.
    do_reset();
    for (int i = 0; i < 8; i++) weights[i] = 8'h10;
    used = '0;
    run(8'hFF, 100, 100, 0, 100, 1);
    used = '0;
    run(8'h21, 100, 100, 0, 40, 1);
    check_eq("rr_pot", potential_out, 11'h0A0);

    // Threshold crossing on the eighth 0x40 spike, then refractory drop.
    do_reset();
    for (int i = 0; i < 8; i++) weights[i] = 8'h40;
    used = '0; fires = 0;
    run(8'hFF, 100, 100, 0, 100, 1);
    check_eq("thr_fires", fires, 1);
    check_eq("thr_pot", potential_out, 0);
    used = '0;
    run(8'h01, 100, 100, 0, 20, 1);
    check_eq("refr_pot", potential_out, 0);
    run(8'h00, 0, 0, 0, 25, 0);
    used = '0;
    run(8'h01, 100, 100, 0, 20, 1);
    check_eq("post_refr_pot", potential_out, 11'h040);

    // Saturation on the second instance.
    for (int i = 0; i < 8; i++) weights[i] = 8'hFF;
    for (int s = 0; s < 9; s++) begin
      spikes2 = 8'(1) << (s % 8);
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        if (acks2 != 0) got = 1;
      end
      check_eq("sat_ack", got, 1);
      spikes2 = '0;
      for (int t = 0; t < 10 && busy2; t++) @(negedge clk);
      check_eq("sat_idle", busy2, 0);
    end
    check_eq("sat_pot", pot2, 11'h7FF);
    check_eq("sat_nospike", seen2, 0);

    // Reset while acknowledging line 2, then re-arbitrate 2 and 4 from pointer 0.
    do_reset();
    for (int i = 0; i < 8; i++) weights[i] = 8'h08;
    used = '0;
    run(8'h04, 100, 0, 0, 6, 1);
    check_eq("pre_rst_ack", acks_out, 8'h04);
    resetn = 1'b0;
    #1;
    check_eq("arst_ack", acks_out, 0);
    check_eq("arst_pot", potential_out, 0);
    check_eq("arst_busy", busy, 0);
    model_reset();
    spikes_in = 8'h14;
    used = 8'h14;
    first_ack = '0;
    @(negedge clk);
    resetn = 1'b1;
    run(8'h14, 0, 100, 0, 40, 1);
    check_eq("first_grant", first_ack, 8'h04);

    // Random traffic with glitching non-granted requests.
    do_reset();
    for (int i = 0; i < 8; i++) weights[i] = 8'($urandom_range(255));
    run(8'hFF, 30, 50, 5, 3000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_rr_scheduler.md
Name: spike_rr_scheduler

Overview:
- Sequences one shared weight ROM and one integrate-and-fire accumulator among N_IN spike requesters.
- Replaces the combinational fixed-priority encoder with a registered round-robin arbiter and a 4-phase request/ack handshake.
- Sits between the hidden-layer spike outputs and the output-layer weight ROM.
- Owns the membrane potential, threshold compare, output spike and refractory period.

Parameters:
- N_IN, 8, number of spike requesters (address width is clog2(N_IN) = 3 at default).
- W_BITS, 8, width of the unsigned weight returned by the ROM.
- ACC_BITS, 11, width of the unsigned membrane potential.
- THETA, 11'h1FF, firing threshold; fires when potential > THETA (strictly greater).
- REFRACTORY, 50000, refractory length in clk cycles after a spike; 0 disables refractory.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- spikes_in  in  N_IN  request lines; requester raises bit i and holds it until acks_out[i]=1.
- acks_out  out  N_IN  one-hot acknowledge; at most one bit high.
- rom_addr  out  3  weight ROM address (registered).
- rom_rd_en  out  1  ROM read strobe (registered).
- rom_data  in  W_BITS  ROM read data; valid the cycle after rom_rd_en=1.
- spike_out  out  1  one-cycle output spike pulse.
- potential_out  out  ACC_BITS  current membrane potential.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, resetn=0) clears:
  - all outputs: acks_out, rom_addr, rom_rd_en, spike_out, potential_out, busy = 0;
  - internal state: state=IDLE, rr pointer=0, grant=0, refractory counter=0.
- FSM states: IDLE, READ, ACCUM, ACK.
- IDLE:
  - If any spikes_in bit is high, grant = first set bit searching upward from the rr pointer, wrapping at N_IN-1 -> 0.
  - If not refractory, go to READ; if refractory, go to ACK (weight discarded, no ROM access).
  - No request: stay in IDLE.
- READ (1 cycle): rom_rd_en=1, rom_addr=grant; go to ACCUM.
- ACCUM (1 cycle): rom_rd_en=0.
  - sum = potential + zero-extended rom_data, computed ACC_BITS+1 wide.
  - On carry, saturate to all-ones.
  - If the saturated sum > THETA: potential <= 0, spike_out=1 in the next cycle, refractory counter <= REFRACTORY.
  - Otherwise potential <= saturated sum.
  - Go to ACK.
- ACK:
  - acks_out[grant]=1 while spikes_in[grant]=1.
  - When spikes_in[grant] is seen low: acks_out <= 0, rr pointer <= grant+1 (mod N_IN), go to IDLE.
  - If the request was already low on ACK entry (protocol violation), ack is high for exactly one cycle.
- Latency: request first sampled at edge k in IDLE:
  - rom_rd_en high in cycle k+1;
  - rom_data sampled at edge k+2;
  - acks_out high from cycle k+3;
  - potential_out updated from cycle k+3.
  - Minimum throughput is one accepted spike per 4 cycles plus requester release time.
- spike_out: registered, exactly one cycle wide, never asserted outside the cycle after a firing ACCUM.
- Refractory counter: decrements by 1 per cycle while nonzero; the neuron is refractory while the counter is nonzero. Spikes granted during refractory are acknowledged and dropped.
- Fairness: a requester that held its request is granted within N_IN grants.
- Requests other than grant may change freely while busy; they are only sampled in IDLE.
- A reset in any state aborts the transaction: ack drops immediately, potential is lost, and held requests are re-arbitrated from pointer 0 after reset.

Test Plan:
- Single request, ROM w[3]=0x40: hold spikes_in=8'h08 -> rom_rd_en=1 with rom_addr=3 at k+1, acks_out=8'h08 at k+3, potential_out=64; release request -> acks_out=0 next cycle, busy=0.
- All 8 requests held, each released when acked, ROM all 0x10: grant order 0,1,...,7. Then re-raise bits 0 and 5 with pointer=0 -> order 0,5. Final potential_out=0xA0.
- Threshold, w[i]=0x40, THETA=0x1FF: 8 sequential spikes -> 7th gives potential 448, 8th gives 512>511 -> spike_out one-cycle pulse, potential_out=0.
- Refractory=20: spike presented during refractory is acked in 2 cycles with no rom_rd_en and potential_out unchanged. The same spike after 20 cycles accumulates normally.
- Saturation, THETA=11'h7FF, w=0xFF: 9 spikes -> potential_out=0x7FF (not wrapped), spike_out never asserted.
- Reset mid-ACK: assert resetn=0 while acks_out=8'h04 -> acks_out, potential_out, busy=0 asynchronously. Release reset with spikes_in=8'h14 -> grant 2 first, then 4.
